uart_sync_fifo: RTL and testbench

// - Single-clock byte FIFO between the UART CSR block and the UART serialiser. One instance serves as TX FIFO, one as RX FIFO.
// - First-word-fall-through: the head entry is visible on rddata while rdvalid=1.
// - Also provides fill level, almost-full/almost-empty flags and sticky overflow/underflow flags.

---
 rtl/uart_sync_fifo.sv | 96 +++++++++
 tb/tb_uart_sync_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// Single-clock FWFT byte FIFO shared by the UART TX and RX paths.
// Tracks fill level, threshold flags and sticky overflow/underflow.
module uart_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     wrvalid,
    output logic                     wrready,
    input  logic [DATA_W-1:0]        wrdata,
    output logic                     rdvalid,
    input  logic                     rdready,
    output logic [DATA_W-1:0]        rddata,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              push, pop;

    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign wrready      = !full;
    assign rdvalid      = !empty;
    assign rddata       = empty ? '0 : mem_q[rd_ptr_q];
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Flush wins over any transfer presented in the same cycle.
    assign push = wrvalid && !full && !flush;
    assign pop  = rdready && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (wrvalid & full);
        udf_d    = udf_q | (rdready & empty);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= wrdata;
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed self-checking bench for uart_sync_fifo.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_uart_sync_fifo;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       flush = 1'b0;
    logic       wrvalid = 1'b0;
    logic       wrready;
    logic [7:0] wrdata = 8'h00;
    logic       rdvalid;
    logic       rdready = 1'b0;
    logic [7:0] rddata;
    logic       empty, full, almost_full, almost_empty;
    logic [4:0] level;
    logic       overflow, underflow;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    uart_sync_fifo dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush),
        .wrvalid(wrvalid), .wrready(wrready), .wrdata(wrdata),
        .rdvalid(rdvalid), .rdready(rdready), .rddata(rddata),
        .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        // 1. reset and idle
        repeat (2) @(negedge aclk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rdvalid", 32'(rdvalid), 32'd0);
        aresetn = 1'b1;
        cyc();
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_full", 32'(full), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_wrready", 32'(wrready), 32'd1);
        chk("idle_rdvalid", 32'(rdvalid), 32'd0);
        chk("idle_rddata", 32'(rddata), 32'h00);
        chk("idle_ae", 32'(almost_empty), 32'd1);
        chk("idle_af", 32'(almost_full), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);
        chk("idle_udf", 32'(underflow), 32'd0);

        // 2. fill with 0x11..0x20, then drain in order
        for (int i = 0; i < 16; i++) begin
            wrvalid = 1'b1;
            wrdata  = 8'(8'h11 + i);
            cyc();
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_af", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk("fill_ae", 32'(almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
        end
        wrvalid = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wrready", 32'(wrready), 32'd0);
        chk("fill_head", 32'(rddata), 32'h11);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(rddata), 32'(8'h11 + i));
            rdready = 1'b1;
            cyc();
        end
        rdready = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_rddata", 32'(rddata), 32'h00);
        chk("drain_udf", 32'(underflow), 32'd0);

        // 3. full: push 0xAA with a pop; push must be rejected
        for (int i = 0; i < 16; i++) begin
            wrvalid = 1'b1;
            wrdata  = 8'(8'h60 + i);
            cyc();
        end
        chk("t3_full", 32'(full), 32'd1);
        wrdata  = 8'hAA;
        rdready = 1'b1;
        cyc();
        wrvalid = 1'b0;
        rdready = 1'b0;
        chk("t3_level", 32'(level), 32'd15);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head", 32'(rddata), 32'h61);
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", 32'(rddata), 32'(8'h60 + i));
            rdready = 1'b1;
            cyc();
        end
        rdready = 1'b0;
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_no_aa", 32'(rddata), 32'h00);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4. empty: push 0x5C with rdready
        wrvalid = 1'b1;
        wrdata  = 8'h5C;
        rdready = 1'b1;
        cyc();
        wrvalid = 1'b0;
        rdready = 1'b0;
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_rddata", 32'(rddata), 32'h5C);
        chk("t4_udf", 32'(underflow), 32'd1);
        rdready = 1'b1;
        cyc();
        rdready = 1'b0;
        chk("t4_empty", 32'(empty), 32'd1);

        // 5. level 8, 40 cycles of simultaneous push+pop
        for (int i = 0; i < 8; i++) begin
            wrvalid = 1'b1;
            wrdata  = 8'(8'h40 + i);
            exp_q.push_back(wrdata);
            cyc();
        end
        chk("t5_level8", 32'(level), 32'd8);
        for (int i = 0; i < 40; i++) begin
            exp_b = exp_q.pop_front();
            chk("t5_order", 32'(rddata), 32'(exp_b));
            wrvalid = 1'b1;
            rdready = 1'b1;
            wrdata  = 8'(8'h80 + i);
            exp_q.push_back(wrdata);
            cyc();
            chk("t5_level", 32'(level), 32'd8);
        end
        wrvalid = 1'b0;
        rdready = 1'b0;
        exp_b = exp_q.pop_front();
        chk("t5_head", 32'(rddata), 32'(exp_b));

        // 6. level 5 with overflow set, flush with push of 0x33
        rdready = 1'b1;
        repeat (3) cyc();
        rdready = 1'b0;
        chk("t6_level5", 32'(level), 32'd5);
        chk("t6_ovf_pre", 32'(overflow), 32'd1);
        flush   = 1'b1;
        wrvalid = 1'b1;
        wrdata  = 8'h33;
        cyc();
        flush   = 1'b0;
        wrvalid = 1'b0;
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_udf", 32'(underflow), 32'd0);
        cyc();
        chk("t6_discard", 32'(rddata), 32'h00);
        chk("t6_rdvalid", 32'(rdvalid), 32'd0);

        // asynchronous reset mid-operation
        wrvalid = 1'b1;
        wrdata  = 8'h77;
        repeat (3) cyc();
        wrvalid = 1'b0;
        chk("ar_level_pre", 32'(level), 32'd3);
        #2 aresetn = 1'b0;
        #1;
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_level", 32'(level), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        chk("ar_after", 32'(rdvalid), 32'd0);
        chk("ar_wrready", 32'(wrready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
